// File: rtl/npc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// npc_sequencer_pkg
// Shared definitions for the next-PC sequencer slice:
//   - default fetch address width, reset PC and sequential increment
//   - sequencer state encoding (RUN / PEND / HALT)
//   - redirect-source encoding, reported by the redirect mux for debug
// -----------------------------------------------------------------------------
package npc_sequencer_pkg;

    localparam int unsigned NPC_PC_WIDTH   = 32;
    localparam logic [31:0] NPC_RESET_PC   = 32'h8000_0000;
    localparam int unsigned NPC_INST_BYTES = 4;

    typedef enum logic [1:0] {
        NPC_RUN  = 2'd0,
        NPC_PEND = 2'd1,
        NPC_HALT = 2'd2
    } npc_state_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_TRAP = 3'd1,
        SRC_MRET = 3'd2,
        SRC_EXEC = 3'd3,
        SRC_DEC  = 3'd4
    } npc_src_e;

endpackage

// File: rtl/npc_redirect_mux.sv
// -----------------------------------------------------------------------------
// npc_redirect_mux
// Pure priority select among redirect sources: trap > mret > execute > decode.
// Ports:
//   trap_vld_i / trap_pc_i   trap request and vector
//   mret_vld_i / mret_pc_i   trap-return request and return address
//   e_vld_i    / e_pc_i      execute-stage redirect
//   d_vld_i    / d_pc_i      decode-stage redirect
//   vld_o                    some source is requesting
//   pc_o                     target of the winning source
//   src_o                    which source won (debug / policy decisions)
// -----------------------------------------------------------------------------
module npc_redirect_mux
    import npc_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH = NPC_PC_WIDTH
) (
    input  logic                trap_vld_i,
    input  logic [PC_WIDTH-1:0] trap_pc_i,
    input  logic                mret_vld_i,
    input  logic [PC_WIDTH-1:0] mret_pc_i,
    input  logic                e_vld_i,
    input  logic [PC_WIDTH-1:0] e_pc_i,
    input  logic                d_vld_i,
    input  logic [PC_WIDTH-1:0] d_pc_i,
    output logic                vld_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output npc_src_e            src_o
);

    // Fixed-priority selection of the highest-ranked requesting source.
    always_comb begin
        vld_o = 1'b0;
        pc_o  = {PC_WIDTH{1'b0}};
        src_o = SRC_NONE;
        if (trap_vld_i) begin
            vld_o = 1'b1;
            pc_o  = trap_pc_i;
            src_o = SRC_TRAP;
        end else if (mret_vld_i) begin
            vld_o = 1'b1;
            pc_o  = mret_pc_i;
            src_o = SRC_MRET;
        end else if (e_vld_i) begin
            vld_o = 1'b1;
            pc_o  = e_pc_i;
            src_o = SRC_EXEC;
        end else if (d_vld_i) begin
            vld_o = 1'b1;
            pc_o  = d_pc_i;
            src_o = SRC_DEC;
        end else begin
            vld_o = 1'b0;
            pc_o  = {PC_WIDTH{1'b0}};
            src_o = SRC_NONE;
        end
    end

endmodule

// File: rtl/npc_sequencer.sv
// -----------------------------------------------------------------------------
// npc_sequencer
// Next-PC controller for the fetch-stage PC register. Chooses between the
// sequential address and decode/execute (and optionally trap/mret) redirects,
// parks a redirect that arrives while fetch is stalled, and pulses flush_o to
// kill younger stages whenever a redirect is taken.
//
// Build option: define NPC_TRAP_EN to add trap_i/trap_vec_i/mret_i/mepc_i;
// without it those ports are absent and priority starts at execute.
//
// Ports:
//   clk_i             clock, all state on posedge
//   rst_n             asynchronous active-low reset
//   F_PC_i            PC currently held by the PC register
//   fetch_allow_in_i  fetch stage accepts a new PC this cycle
//   D_redirect_i/D_target_i   decode redirect request / target
//   E_redirect_i/E_target_i   execute redirect request / target
//   halt_i            stop fetching, sticky until reset
//   trap_i/trap_vec_i, mret_i/mepc_i   (NPC_TRAP_EN only)
//   nPC_o             next PC offered to the PC register (combinational)
//   PC_ready_o        nPC_o valid (combinational)
//   flush_o           one-cycle kill pulse per taken redirect (combinational)
// -----------------------------------------------------------------------------
module npc_sequencer
    import npc_sequencer_pkg::*;
#(
    parameter int unsigned          PC_WIDTH   = NPC_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = PC_WIDTH'(NPC_RESET_PC),
    parameter int unsigned          INST_BYTES = NPC_INST_BYTES
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] F_PC_i,
    input  logic                fetch_allow_in_i,
    input  logic                D_redirect_i,
    input  logic [PC_WIDTH-1:0] D_target_i,
    input  logic                E_redirect_i,
    input  logic [PC_WIDTH-1:0] E_target_i,
    input  logic                halt_i,
`ifdef NPC_TRAP_EN
    input  logic                trap_i,
    input  logic [PC_WIDTH-1:0] trap_vec_i,
    input  logic                mret_i,
    input  logic [PC_WIDTH-1:0] mepc_i,
`endif
    output logic [PC_WIDTH-1:0] nPC_o,
    output logic                PC_ready_o,
    output logic                flush_o
);

    localparam logic [PC_WIDTH-1:0] INC_PC   = PC_WIDTH'(INST_BYTES);
    localparam logic [PC_WIDTH-1:0] BOOT_NPC = RESET_PC + INC_PC;

    npc_state_e          state_q, state_d;
    logic                pend_vld_q, pend_vld_d;
    logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
    // Low for the first cycle out of reset so PC_ready_o rises one cycle later.
    logic                live_q;

    logic                trap_vld_s, mret_vld_s;
    logic [PC_WIDTH-1:0] trap_pc_s, mret_pc_s;
    logic                redir_vld_s;
    logic [PC_WIDTH-1:0] redir_pc_s;
    npc_src_e            redir_src_s;
    logic                take_s;
    logic [PC_WIDTH-1:0] seq_pc_s;

`ifdef NPC_TRAP_EN
    assign trap_vld_s = trap_i;
    assign trap_pc_s  = trap_vec_i;
    assign mret_vld_s = mret_i;
    assign mret_pc_s  = mepc_i;
`else
    assign trap_vld_s = 1'b0;
    assign trap_pc_s  = {PC_WIDTH{1'b0}};
    assign mret_vld_s = 1'b0;
    assign mret_pc_s  = {PC_WIDTH{1'b0}};
`endif

    npc_redirect_mux #(
        .PC_WIDTH (PC_WIDTH)
    ) u_redirect_mux (
        .trap_vld_i (trap_vld_s),
        .trap_pc_i  (trap_pc_s),
        .mret_vld_i (mret_vld_s),
        .mret_pc_i  (mret_pc_s),
        .e_vld_i    (E_redirect_i),
        .e_pc_i     (E_target_i),
        .d_vld_i    (D_redirect_i),
        .d_pc_i     (D_target_i),
        .vld_o      (redir_vld_s),
        .pc_o       (redir_pc_s),
        .src_o      (redir_src_s)
    );

    // Sequential address wraps silently at the top of the address space.
    assign seq_pc_s = F_PC_i + INC_PC;

    // A decode redirect may not displace a parked redirect: a pending entry
    // always came from an older, already-resolved redirect decision. Since D
    // is the lowest source, "winner is D" means nothing stronger is present.
    assign take_s = live_q && redir_vld_s &&
                    ((state_q == NPC_RUN) ||
                     ((state_q == NPC_PEND) && (redir_src_s != SRC_DEC)));

    // State, pending-redirect and reset-release registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NPC_RUN;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= {PC_WIDTH{1'b0}};
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
            live_q     <= 1'b1;
        end
    end

    // Next-state logic: park stalled redirects, release them on allow_in.
    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        case (state_q)
            NPC_RUN: begin
                if (take_s && !fetch_allow_in_i) begin
                    state_d    = NPC_PEND;
                    pend_vld_d = 1'b1;
                    pend_pc_d  = redir_pc_s;
                end else begin
                    state_d    = NPC_RUN;
                end
            end
            NPC_PEND: begin
                if (take_s && !fetch_allow_in_i) begin
                    // Newest stronger redirect replaces the parked one.
                    pend_pc_d  = redir_pc_s;
                end else if (take_s || fetch_allow_in_i) begin
                    state_d    = NPC_RUN;
                    pend_vld_d = 1'b0;
                end else begin
                    state_d    = NPC_PEND;
                end
            end
            NPC_HALT: begin
                state_d    = NPC_HALT;
                pend_vld_d = 1'b0;
            end
            default: begin
                state_d    = NPC_RUN;
                pend_vld_d = 1'b0;
                pend_pc_d  = {PC_WIDTH{1'b0}};
            end
        endcase
        // Halt overrides everything and discards any parked redirect.
        if (halt_i) begin
            state_d    = NPC_HALT;
            pend_vld_d = 1'b0;
        end else begin
            state_d    = state_d;
        end
    end

    // Output logic: zero-latency nPC/ready/flush from state and inputs.
    always_comb begin
        nPC_o      = BOOT_NPC;
        PC_ready_o = 1'b0;
        flush_o    = 1'b0;
        if (live_q) begin
            case (state_q)
                NPC_RUN: begin
                    PC_ready_o = 1'b1;
                    flush_o    = take_s;
                    nPC_o      = take_s ? redir_pc_s : seq_pc_s;
                end
                NPC_PEND: begin
                    PC_ready_o = 1'b1;
                    flush_o    = take_s;
                    if (take_s) begin
                        nPC_o = redir_pc_s;
                    end else if (pend_vld_q) begin
                        nPC_o = pend_pc_q;
                    end else begin
                        nPC_o = seq_pc_s;
                    end
                end
                NPC_HALT: begin
                    PC_ready_o = 1'b0;
                    flush_o    = 1'b0;
                    nPC_o      = F_PC_i;
                end
                default: begin
                    PC_ready_o = 1'b0;
                    flush_o    = 1'b0;
                    nPC_o      = seq_pc_s;
                end
            endcase
        end else begin
            nPC_o      = BOOT_NPC;
            PC_ready_o = 1'b0;
            flush_o    = 1'b0;
        end
    end

endmodule

// File: tb/tb_npc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_npc_sequencer
// Self-checking bench for npc_sequencer: directed scenarios plus a randomized
// run against a behavioural next-PC model kept in this file.
// -----------------------------------------------------------------------------
module tb_npc_sequencer;

`ifdef NPC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk, rst_n;
    logic [31:0] f_pc, d_t, e_t, tv, mepc;
    logic        allow, d_r, e_r, halt, trap, mret;
    logic [31:0] npc;
    logic        rdy, fl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model state
    bit          m_live, m_halted, m_pend, m_take;
    logic [31:0] m_pend_pc, m_tgt;
    logic [31:0] exp_npc;
    logic        exp_rdy, exp_fl;

    npc_sequencer dut (
        .clk_i            (clk),
        .rst_n            (rst_n),
        .F_PC_i           (f_pc),
        .fetch_allow_in_i (allow),
        .D_redirect_i     (d_r),
        .D_target_i       (d_t),
        .E_redirect_i     (e_r),
        .E_target_i       (e_t),
        .halt_i           (halt),
`ifdef NPC_TRAP_EN
        .trap_i           (trap),
        .trap_vec_i       (tv),
        .mret_i           (mret),
        .mepc_i           (mepc),
`endif
        .nPC_o            (npc),
        .PC_ready_o       (rdy),
        .flush_o          (fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected outputs for the current inputs, by priority rule.
    task automatic model_eval();
        bit hit;
        logic [31:0] tgt;
        hit = 1'b0;
        tgt = 32'h0;
        if (TRAP_EN && trap)               begin hit = 1'b1; tgt = tv;   end
        else if (TRAP_EN && mret)          begin hit = 1'b1; tgt = mepc; end
        else if (e_r)                      begin hit = 1'b1; tgt = e_t;  end
        else if (d_r && !m_pend)           begin hit = 1'b1; tgt = d_t;  end
        if (!m_live) begin
            exp_npc = RST_PC + 32'd4; exp_rdy = 1'b0; exp_fl = 1'b0;
        end else if (m_halted) begin
            exp_npc = f_pc; exp_rdy = 1'b0; exp_fl = 1'b0;
        end else if (hit) begin
            exp_npc = tgt; exp_rdy = 1'b1; exp_fl = 1'b1;
        end else if (m_pend) begin
            exp_npc = m_pend_pc; exp_rdy = 1'b1; exp_fl = 1'b0;
        end else begin
            exp_npc = f_pc + 32'd4; exp_rdy = 1'b1; exp_fl = 1'b0;
        end
        m_take = hit && m_live && !m_halted;
        m_tgt  = tgt;
    endtask

    task automatic model_reset();
        m_live = 1'b0; m_halted = 1'b0; m_pend = 1'b0; m_pend_pc = 32'h0;
    endtask

    // Advance model and DUT by one clock edge.
    task automatic tick();
        if (m_live && !m_halted) begin
            if (m_take) begin
                m_pend    = !allow;
                m_pend_pc = m_tgt;
            end else if (m_pend && allow) begin
                m_pend = 1'b0;
            end
        end
        if (halt) begin
            m_halted = 1'b1;
            m_pend   = 1'b0;
        end
        m_live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        allow = 1'b1; d_r = 1'b0; e_r = 1'b0; halt = 1'b0; trap = 1'b0; mret = 1'b0;
        d_t = 32'h0; e_t = 32'h0; tv = 32'h0; mepc = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        f_pc = 32'h1234_5670;
        rst_n = 1'b0;
        model_reset();
        #12;
        model_eval();
        total_cnt++; if (npc !== 32'h8000_0004) $display("FAIL reset_npc: got %h want %h", npc, 32'h8000_0004); else pass_cnt++;
        total_cnt++; if (rdy !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy); else pass_cnt++;
        total_cnt++; if (fl !== 1'b0) $display("FAIL reset_flush: got %b want 0", fl); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (rdy !== 1'b0) $display("FAIL release_ready_early: got %b want 0", rdy); else pass_cnt++;
        tick();
    endtask

    task automatic test_sequential();
        f_pc = 32'h8000_0000; allow = 1'b1;
        #3; model_eval();
        total_cnt++; if (npc !== 32'h8000_0004) $display("FAIL seq_npc: got %h want %h", npc, 32'h8000_0004); else pass_cnt++;
        total_cnt++; if (rdy !== 1'b1) $display("FAIL seq_ready: got %b want 1", rdy); else pass_cnt++;
        total_cnt++; if (fl !== 1'b0) $display("FAIL seq_flush: got %b want 0", fl); else pass_cnt++;
        tick();
    endtask

    task automatic test_e_beats_d();
        f_pc = 32'h8000_0004;
        e_r = 1'b1; e_t = 32'h8000_0100; d_r = 1'b1; d_t = 32'h8000_0040;
        #3; model_eval();
        total_cnt++; if (npc !== 32'h8000_0100) $display("FAIL e_beats_d_npc: got %h want %h", npc, 32'h8000_0100); else pass_cnt++;
        total_cnt++; if (fl !== 1'b1) $display("FAIL e_beats_d_flush: got %b want 1", fl); else pass_cnt++;
        tick();
        e_r = 1'b0; d_r = 1'b0; f_pc = 32'h8000_0100;
        #3; model_eval();
        total_cnt++; if (fl !== 1'b0) $display("FAIL e_beats_d_pulse: got %b want 0", fl); else pass_cnt++;
        total_cnt++; if (npc !== 32'h8000_0104) $display("FAIL e_beats_d_after: got %h want %h", npc, 32'h8000_0104); else pass_cnt++;
        tick();
    endtask

    task automatic test_pend();
        int flushes;
        flushes = 0;
        f_pc = 32'h8000_0010; allow = 1'b0;
        e_r = 1'b1; e_t = 32'h8000_0200;
        #3; model_eval();
        total_cnt++; if (npc !== 32'h8000_0200) $display("FAIL pend_take_npc: got %h want %h", npc, 32'h8000_0200); else pass_cnt++;
        if (fl === 1'b1) flushes++;
        tick();
        e_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            allow = (i == 2);
            #3; model_eval();
            total_cnt++; if (npc !== 32'h8000_0200) $display("FAIL pend_hold_npc[%0d]: got %h want %h", i, npc, 32'h8000_0200); else pass_cnt++;
            total_cnt++; if (rdy !== 1'b1) $display("FAIL pend_hold_ready[%0d]: got %b want 1", i, rdy); else pass_cnt++;
            if (fl === 1'b1) flushes++;
            tick();
        end
        f_pc = 32'h8000_0200;
        #3; model_eval();
        total_cnt++; if (npc !== 32'h8000_0204) $display("FAIL pend_back_to_run: got %h want %h", npc, 32'h8000_0204); else pass_cnt++;
        if (fl === 1'b1) flushes++;
        tick();
        total_cnt++; if (flushes != 1) $display("FAIL pend_flush_count: got %0d want 1", flushes); else pass_cnt++;
    endtask

    task automatic test_wrap();
        f_pc = 32'hFFFF_FFFC; allow = 1'b1;
        #3; model_eval();
        total_cnt++; if (npc !== 32'h0000_0000) $display("FAIL wrap_npc: got %h want %h", npc, 32'h0); else pass_cnt++;
        tick();
    endtask

    task automatic test_trap();
        logic [31:0] want;
        f_pc = 32'h8000_0300;
        trap = 1'b1; tv = 32'h8000_0800; mret = 1'b1; mepc = 32'h8000_0900;
        e_r = 1'b1; e_t = 32'h8000_0A00;
        want = TRAP_EN ? 32'h8000_0800 : 32'h8000_0A00;
        #3; model_eval();
        total_cnt++; if (npc !== want) $display("FAIL trap_priority: got %h want %h", npc, want); else pass_cnt++;
        total_cnt++; if (fl !== 1'b1) $display("FAIL trap_flush: got %b want 1", fl); else pass_cnt++;
        tick();
        trap = 1'b0;
        want = TRAP_EN ? 32'h8000_0900 : 32'h8000_0A00;
        #3; model_eval();
        total_cnt++; if (npc !== want) $display("FAIL mret_priority: got %h want %h", npc, want); else pass_cnt++;
        tick();
        mret = 1'b0; e_r = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgts [4];
        tgts[0] = 32'h8000_1000; tgts[1] = 32'h8000_2000; tgts[2] = 32'h8000_3000;
        tgts[3] = 32'h8000_3000;
        allow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_pc = (i == 3) ? 32'h8000_3000 : 32'h8000_0500;  // last: target == F_PC
            if (i == 2) begin d_r = 1'b1; d_t = tgts[i]; e_r = 1'b0; end
            else        begin e_r = 1'b1; e_t = tgts[i]; d_r = 1'b0; end
            #3; model_eval();
            total_cnt++; if (npc !== tgts[i]) $display("FAIL b2b_npc[%0d]: got %h want %h", i, npc, tgts[i]); else pass_cnt++;
            total_cnt++; if (fl !== 1'b1) $display("FAIL b2b_flush[%0d]: got %b want 1", i, fl); else pass_cnt++;
            tick();
        end
        e_r = 1'b0; d_r = 1'b0;
    endtask

    task automatic test_reset_mid_pend();
        f_pc = 32'h8000_0040; allow = 1'b0; e_r = 1'b1; e_t = 32'h8000_0700;
        #3; model_eval(); tick();
        e_r = 1'b0;
        #3; model_eval();
        total_cnt++; if (npc !== 32'h8000_0700) $display("FAIL rstpend_hold: got %h want %h", npc, 32'h8000_0700); else pass_cnt++;
        rst_n = 1'b0;
        model_reset();
        #1;
        total_cnt++; if (rdy !== 1'b0) $display("FAIL rstpend_ready: got %b want 0", rdy); else pass_cnt++;
        total_cnt++; if (npc !== 32'h8000_0004) $display("FAIL rstpend_npc: got %h want %h", npc, 32'h8000_0004); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        model_eval();
        tick();
        f_pc = 32'h8000_0000; allow = 1'b1;
        #3; model_eval();
        total_cnt++; if (npc !== 32'h8000_0004) $display("FAIL rstpend_restart: got %h want %h", npc, 32'h8000_0004); else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            allow = ($urandom_range(3) != 0);
            e_r   = ($urandom_range(4) == 0);
            d_r   = ($urandom_range(3) == 0);
            trap  = ($urandom_range(9) == 0);
            mret  = ($urandom_range(9) == 0);
            f_pc  = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            e_t   = ($urandom_range(7) == 0) ? f_pc : ($urandom() & 32'hFFFF_FFFC);
            d_t   = $urandom() & 32'hFFFF_FFFC;
            tv    = $urandom() & 32'hFFFF_FFFC;
            mepc  = $urandom() & 32'hFFFF_FFFC;
            #3; model_eval();
            total_cnt++; if (npc !== exp_npc) $display("FAIL rand_npc[%0d]: got %h want %h", i, npc, exp_npc); else pass_cnt++;
            total_cnt++; if (rdy !== exp_rdy) $display("FAIL rand_ready[%0d]: got %b want %b", i, rdy, exp_rdy); else pass_cnt++;
            total_cnt++; if (fl !== exp_fl) $display("FAIL rand_flush[%0d]: got %b want %b", i, fl, exp_fl); else pass_cnt++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        f_pc = 32'h8000_0080; allow = 1'b0; e_r = 1'b1; e_t = 32'h8000_0500;
        #3; model_eval(); tick();
        e_r = 1'b0; halt = 1'b1;
        #3; model_eval();
        total_cnt++; if (rdy !== 1'b1 || npc !== 32'h8000_0500) $display("FAIL halt_same_cycle: got %b/%h want 1/%h", rdy, npc, 32'h8000_0500); else pass_cnt++;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            allow = 1'b1; e_r = 1'b1; d_r = 1'b1;
            e_t = $urandom() & 32'hFFFF_FFFC; d_t = $urandom() & 32'hFFFF_FFFC;
            f_pc = 32'h8000_0444 + 32'(i * 4);
            #3; model_eval();
            total_cnt++; if (rdy !== 1'b0) $display("FAIL halt_ready[%0d]: got %b want 0", i, rdy); else pass_cnt++;
            total_cnt++; if (fl !== 1'b0) $display("FAIL halt_flush[%0d]: got %b want 0", i, fl); else pass_cnt++;
            total_cnt++; if (npc !== exp_npc) $display("FAIL halt_npc[%0d]: got %h want %h", i, npc, exp_npc); else pass_cnt++;
            tick();
        end
        clear_inputs();
        rst_n = 1'b0; model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_eval(); tick();
        f_pc = 32'h8000_0000;
        #3; model_eval();
        total_cnt++; if (rdy !== 1'b1 || npc !== 32'h8000_0004) $display("FAIL halt_exit_reset: got %b/%h want 1/%h", rdy, npc, 32'h8000_0004); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_e_beats_d();
        test_pend();
        test_wrap();
        test_trap();
        test_back_to_back();
        test_reset_mid_pend();
        test_random();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
